// File: rtl/phase7_pkg.sv
// phase7_pkg
//   Shared definitions for the modulo-7 phase counter and its monitor.
//   - phase7_state_t : monitor FSM states (IDLE, ACQ, LOCKED)
//   - PHASE_MAX      : last phase before the count returns to 0
//   - LOAD_PHASE     : phase forced when the load input is high
//   - phase7_next()  : next phase of the upstream counter given (a, q),
//                      also used by the upstream counter's reference model
package phase7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } phase7_state_t;

    localparam logic [2:0] PHASE_MAX  = 3'd6;
    localparam logic [2:0] LOAD_PHASE = 3'd4;

    // Evaluated in 3 bits: an out-of-range phase 7 steps to 0.
    function automatic logic [2:0] phase7_next(input logic a, input logic [2:0] q);
        if (a) begin
            return LOAD_PHASE;
        end else if (q == PHASE_MAX) begin
            return 3'd0;
        end else begin
            return q + 3'd1;
        end
    endfunction

endpackage

// File: rtl/phase7_predict.sv
// phase7_predict
//   Combinational predictor of the next upstream phase from the previous
//   (a, q) sample, with flags classifying the predicted step.
// Ports:
//   a_prev   in  1  load input sampled on the previous edge
//   q_prev   in  3  phase sampled on the previous edge
//   exp      out 3  predicted phase for the current sample
//   is_wrap  out 1  predicted step is the natural 6 -> 0 wrap
//   is_load  out 1  predicted step is a load to LOAD_PHASE
module phase7_predict
    import phase7_pkg::*;
(
    input  logic       a_prev,
    input  logic [2:0] q_prev,
    output logic [2:0] exp,
    output logic       is_wrap,
    output logic       is_load
);

    assign exp     = phase7_next(a_prev, q_prev);
    assign is_wrap = !a_prev && (q_prev == PHASE_MAX);
    assign is_load = a_prev;

endmodule

// File: rtl/phase7_monitor.sv
// phase7_monitor
//   Checks the (a, q) stream of a modulo-7 phase counter every cycle,
//   acquires lock after LOCK_CNT consecutive legal steps, and reports
//   illegal steps, wraps and loads as registered one-cycle pulses with
//   a saturating error counter and a wrapping revolution counter.
// Parameters:
//   LOCK_CNT  legal steps needed to lock (1..15)
//   ERR_W     width of the saturating error counter
//   WRAP_W    width of the wrapping revolution counter
// Ports:
//   clk         in  1       clock, rising edge
//   reset       in  1       asynchronous active-high reset
//   a           in  1       upstream load input
//   q           in  3       upstream phase
//   locked      out 1       high while LOCKED
//   err         out 1       pulse on an illegal step (ACQ/LOCKED)
//   wrap        out 1       pulse on a legal 6 -> 0 step while LOCKED
//   load_seen   out 1       pulse on a legal load step (ACQ/LOCKED)
//   err_count   out ERR_W   saturating count of err pulses
//   wrap_count  out WRAP_W  count of wrap pulses, modulo 2^WRAP_W
module phase7_monitor
    import phase7_pkg::*;
#(
    parameter int LOCK_CNT = 7,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a,
    input  logic [2:0]        q,
    output logic              locked,
    output logic              err,
    output logic              wrap,
    output logic              load_seen,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count
);

    localparam logic [3:0]        LOCK_RUN = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    phase7_state_t state;
    phase7_state_t state_nxt;
    logic [3:0]    run;
    logic [3:0]    run_nxt;
    logic [2:0]    q_prev;
    logic          a_prev;

    logic [2:0]    exp_q;
    logic          is_wrap;
    logic          is_load;
    logic          legal;

    logic          err_nxt;
    logic          wrap_nxt;
    logic          load_nxt;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_ONE;
    endfunction

    phase7_predict u_predict (
        .a_prev  (a_prev),
        .q_prev  (q_prev),
        .exp     (exp_q),
        .is_wrap (is_wrap),
        .is_load (is_load)
    );

    // The predictor never yields 7, but 7 is rejected explicitly so that
    // legality never depends on that property.
    assign legal = (q == exp_q) && (q != 3'd7);

    // State register and previous-sample capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            run    <= '0;
            q_prev <= '0;
            a_prev <= 1'b0;
        end else begin
            state  <= state_nxt;
            run    <= run_nxt;
            q_prev <= q;
            a_prev <= a;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        unique case (state)
            IDLE: begin
                // First sample only seeds q_prev/a_prev; it is never judged.
                if (q != 3'd7) begin
                    state_nxt = ACQ;
                    run_nxt   = '0;
                end
            end
            ACQ: begin
                if (legal) begin
                    run_nxt = run + 4'd1;
                    if (run + 4'd1 == LOCK_RUN) begin
                        state_nxt = LOCKED;
                    end
                end else begin
                    run_nxt = '0;
                end
            end
            LOCKED: begin
                if (!legal) begin
                    state_nxt = ACQ;
                    run_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                run_nxt   = '0;
            end
        endcase
    end

    // Pulse decode for the current sample
    always_comb begin
        err_nxt  = 1'b0;
        wrap_nxt = 1'b0;
        load_nxt = 1'b0;
        if (state == ACQ || state == LOCKED) begin
            err_nxt  = !legal;
            load_nxt = legal && is_load;
            wrap_nxt = (state == LOCKED) && legal && is_wrap;
        end
    end

    // Output registers: counters update on the same edge as their pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked     <= 1'b0;
            err        <= 1'b0;
            wrap       <= 1'b0;
            load_seen  <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            locked    <= (state_nxt == LOCKED);
            err       <= err_nxt;
            wrap      <= wrap_nxt;
            load_seen <= load_nxt;
            if (err_nxt) begin
                err_count <= sat_inc(err_count);
            end
            if (wrap_nxt) begin
                wrap_count <= wrap_count + WRAP_ONE;
            end
        end
    end

endmodule

// File: tb/tb_phase7_monitor.sv
// Testbench for phase7_monitor: two instances (default parameters and a
// small LOCK_CNT / ERR_W / WRAP_W variant) driven by the same stream,
// checked every edge against a behavioural model of the monitoring rules.
module tb_phase7_monitor;

    localparam int LC1 = 7;
    localparam int EW1 = 8;
    localparam int WW1 = 16;
    localparam int LC2 = 3;
    localparam int EW2 = 2;
    localparam int WW2 = 2;

    logic           clk;
    logic           reset;
    logic           a;
    logic [2:0]     q;

    logic           d1_locked, d1_err, d1_wrap, d1_load;
    logic [EW1-1:0] d1_ec;
    logic [WW1-1:0] d1_wc;
    logic           d2_locked, d2_err, d2_wrap, d2_load;
    logic [EW2-1:0] d2_ec;
    logic [WW2-1:0] d2_wc;

    phase7_monitor #(.LOCK_CNT(LC1), .ERR_W(EW1), .WRAP_W(WW1)) dut1 (
        .clk(clk), .reset(reset), .a(a), .q(q),
        .locked(d1_locked), .err(d1_err), .wrap(d1_wrap), .load_seen(d1_load),
        .err_count(d1_ec), .wrap_count(d1_wc)
    );

    phase7_monitor #(.LOCK_CNT(LC2), .ERR_W(EW2), .WRAP_W(WW2)) dut2 (
        .clk(clk), .reset(reset), .a(a), .q(q),
        .locked(d2_locked), .err(d2_err), .wrap(d2_wrap), .load_seen(d2_load),
        .err_count(d2_ec), .wrap_count(d2_wc)
    );

    // Behavioural view of the monitor: has it seen a first usable sample,
    // how long is the current run of legal steps, is it locked, and the
    // unbounded totals of errors and wraps.
    typedef struct {
        bit started;
        int streak;
        bit locked;
        bit err;
        bit wrap;
        bit load;
        int errs;
        int wraps;
        int pq;
        bit pa;
    } mdl_t;

    mdl_t m1, m2;
    int   tests;
    int   fails;
    int   tick_no;
    int   up_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream counter contract: load 4, else count modulo 7.
    function automatic int ctr_next(bit la, int cq);
        return la ? 4 : (cq + 1) % 7;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit sa, int sq, int lock_cnt);
        mdl_t n;
        int   want;
        n      = m;
        n.err  = 1'b0;
        n.wrap = 1'b0;
        n.load = 1'b0;
        if (!m.started) begin
            if (sq != 7) begin
                n.started = 1'b1;
                n.streak  = 0;
            end
        end else begin
            want = m.pa ? 4 : ((m.pq == 6) ? 0 : (m.pq + 1) % 8);
            if (sq == want) begin
                n.load = m.pa;
                if (m.locked) begin
                    if (!m.pa && m.pq == 6) begin
                        n.wrap  = 1'b1;
                        n.wraps = m.wraps + 1;
                    end
                end else begin
                    n.streak = m.streak + 1;
                    if (n.streak >= lock_cnt) n.locked = 1'b1;
                end
            end else begin
                n.err    = 1'b1;
                n.errs   = m.errs + 1;
                n.streak = 0;
                n.locked = 1'b0;
            end
        end
        n.pq = sq;
        n.pa = sa;
        return n;
    endfunction

    function automatic int exp_ec(int errs, int ew);
        int mx;
        mx = (1 << ew) - 1;
        return (errs > mx) ? mx : errs;
    endfunction

    function automatic int exp_wc(int wraps, int ww);
        return wraps % (1 << ww);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s tick=%0d observed=%0d expected=%0d", tag, tick_no, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("d1_locked",     32'(d1_locked), 32'(m1.locked));
        chk("d1_err",        32'(d1_err),    32'(m1.err));
        chk("d1_wrap",       32'(d1_wrap),   32'(m1.wrap));
        chk("d1_load_seen",  32'(d1_load),   32'(m1.load));
        chk("d1_err_count",  32'(d1_ec),     32'(exp_ec(m1.errs, EW1)));
        chk("d1_wrap_count", 32'(d1_wc),     32'(exp_wc(m1.wraps, WW1)));
        chk("d2_locked",     32'(d2_locked), 32'(m2.locked));
        chk("d2_err",        32'(d2_err),    32'(m2.err));
        chk("d2_wrap",       32'(d2_wrap),   32'(m2.wrap));
        chk("d2_load_seen",  32'(d2_load),   32'(m2.load));
        chk("d2_err_count",  32'(d2_ec),     32'(exp_ec(m2.errs, EW2)));
        chk("d2_wrap_count", 32'(d2_wc),     32'(exp_wc(m2.wraps, WW2)));
    endtask

    // Drive one sample between edges, let the next rising edge judge it,
    // then compare both instances just after that edge.
    task automatic tick(bit sa, int sq);
        @(negedge clk);
        a = sa;
        q = 3'(sq);
        @(posedge clk);
        #1;
        tick_no++;
        m1 = mstep(m1, sa, sq, LC1);
        m2 = mstep(m2, sa, sq, LC2);
        check_all();
    endtask

    task automatic clean_run(int n, int load_odds);
        bit la;
        for (int i = 0; i < n; i++) begin
            la = (load_odds > 0) && ($urandom_range(0, load_odds - 1) == 0);
            tick(la, up_q);
            up_q = ctr_next(la, up_q);
        end
    endtask

    initial begin
        int lock_edge1;
        int lock_edge2;
        int loads;
        int ec_before;
        bit la;
        int sq;

        tests   = 0;
        fails   = 0;
        tick_no = 0;
        reset   = 1'b0;
        a       = 1'b0;
        q       = 3'd0;
        m1      = '{default: 0};
        m2      = '{default: 0};

        // Reset asserted before any clock edge: outputs clear asynchronously
        #1 reset = 1'b1;
        #2;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();

        // Clean run from release: lock at edge LOCK_CNT+1
        @(posedge clk);
        #3 reset = 1'b0;
        up_q       = 0;
        lock_edge1 = 0;
        lock_edge2 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, up_q);
            up_q = ctr_next(1'b0, up_q);
            if (d1_locked && lock_edge1 == 0) lock_edge1 = k;
            if (d2_locked && lock_edge2 == 0) lock_edge2 = k;
        end
        chk("lock_edge_default", 32'(lock_edge1), 32'(LC1 + 1));
        chk("lock_edge_small",   32'(lock_edge2), 32'(LC2 + 1));

        // Load while locked: q = 3,4,4,4,5 gives three load pulses
        for (int i = 0; i < 7 && up_q != 3; i++) begin
            tick(1'b0, up_q);
            up_q = ctr_next(1'b0, up_q);
        end
        loads = 0;
        for (int i = 0; i < 5; i++) begin
            la = (i < 3);
            tick(la, up_q);
            up_q = ctr_next(la, up_q);
            loads += int'(d1_load);
        end
        chk("load_pulses", 32'(loads), 32'd3);

        // Random loads on a clean stream
        clean_run(40, 5);

        // Single glitch to 7 while locked, then recovery
        ec_before = int'(d1_ec);
        tick(1'b0, 7);
        up_q = ctr_next(1'b0, up_q);
        chk("glitch_err_count", 32'(d1_ec), 32'(ec_before + 1));
        clean_run(20, 0);

        // Random illegal phases mixed into the stream
        for (int i = 0; i < 40; i++) begin
            la = ($urandom_range(0, 5) == 0);
            sq = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : up_q;
            tick(la, sq);
            up_q = ctr_next(la, up_q);
        end

        // Five consecutive illegal samples: small counter pinned at all-ones
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 7);
            up_q = ctr_next(1'b0, up_q);
        end
        chk("err_saturated", 32'(d2_ec), 32'd3);

        // Long clean stretch: many wraps, small wrap counter rolls over
        clean_run(70, 0);

        // Asynchronous reset between edges while locked with errors logged
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        m1 = '{default: 0};
        m2 = '{default: 0};
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(posedge clk);
        #3 reset = 1'b0;

        // Discontinuous first sample after release is only captured
        tick(1'b0, 5);
        up_q = ctr_next(1'b0, 5);
        clean_run(15, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
